// File: rtl/cpu_sequencer.sv
// cpu_sequencer: instruction sequencer and instruction register.
// Drives the one-hot FETCH/EXEC1/EXEC2 strobes for decode, latches the
// instruction word into IR/N, and handles STP halt, run start-up and a
// saturating retired-instruction counter.
// Optional feature macro: SINGLE_STEP_EN (adds step_mode/step ports and
// pauses in IDLE after every retired instruction while step_mode=1).
module cpu_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [15:0] ram_q,
    input  logic        EXTRA,
`ifdef SINGLE_STEP_EN
    input  logic        step_mode,
    input  logic        step,
`endif
    output logic        FETCH,
    output logic        EXEC1,
    output logic        EXEC2,
    output logic [3:0]  IR,
    output logic [11:0] N,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam logic [3:0] OP_STP = 4'b0111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC1,
        S_EXEC2,
        S_HALT
    } state_t;

    state_t      state_q, state_d;
    state_t      retire_next;
    logic        run_q, run_d;
    logic        start;
    logic        go_idle;
    logic        retire;
    logic [3:0]  ir_q, ir_d;
    logic [11:0] n_q, n_d;
    logic [15:0] count_q, count_d;
    logic        fetch_q, fetch_d;
    logic        exec1_q, exec1_d;
    logic        exec2_q, exec2_d;
    logic        halted_q, halted_d;
`ifdef SINGLE_STEP_EN
    logic        step_q, step_d;
    logic        step_go;
`endif

    // Next-state, instruction capture, retire counting and strobe decode
    always_comb begin
        run_d   = run;
        start   = run & ~run_q;
`ifdef SINGLE_STEP_EN
        step_d      = step;
        step_go     = step & ~step_q;
        go_idle     = start | step_go;
        retire_next = step_mode ? S_IDLE : S_FETCH;
`else
        go_idle     = start;
        retire_next = S_FETCH;
`endif
        state_d = state_q;
        ir_d    = ir_q;
        n_d     = n_q;
        count_d = count_q;
        retire  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go_idle) state_d = S_FETCH;
            end
            S_FETCH: begin
                state_d = S_EXEC1;
                ir_d    = ram_q[15:12];
                n_d     = ram_q[11:0];
            end
            S_EXEC1: begin
                // EXTRA takes priority over STP decode
                if (EXTRA) begin
                    state_d = S_EXEC2;
                end else if (ir_q == OP_STP) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = retire_next;
                    retire  = 1'b1;
                end
            end
            S_EXEC2: begin
                state_d = retire_next;
                retire  = 1'b1;
            end
            S_HALT: begin
                if (start) state_d = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase

        if (retire && (count_q != '1)) count_d = count_q + 16'd1;

        // Strobes are registered copies of the next state, so they track
        // state_q exactly and never depend combinationally on inputs.
        fetch_d  = (state_d == S_FETCH);
        exec1_d  = (state_d == S_EXEC1);
        exec2_d  = (state_d == S_EXEC2);
        halted_d = (state_d == S_HALT);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            run_q    <= 1'b0;
            ir_q     <= '0;
            n_q      <= '0;
            count_q  <= '0;
            fetch_q  <= 1'b0;
            exec1_q  <= 1'b0;
            exec2_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef SINGLE_STEP_EN
            step_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            ir_q     <= ir_d;
            n_q      <= n_d;
            count_q  <= count_d;
            fetch_q  <= fetch_d;
            exec1_q  <= exec1_d;
            exec2_q  <= exec2_d;
            halted_q <= halted_d;
`ifdef SINGLE_STEP_EN
            step_q   <= step_d;
`endif
        end
    end

    assign FETCH       = fetch_q;
    assign EXEC1       = exec1_q;
    assign EXEC2       = exec2_q;
    assign IR          = ir_q;
    assign N           = n_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
